// File: rtl/im_stream_sender_if.sv
// im_stream_sender_if: upstream coefficient/pixel handshakes plus the filter-side stream.
interface im_stream_sender_if #(
   parameter int DATA_BIT   = 15,
   parameter int DATA_IDBIT = 1,
   parameter int COFCNT_BIT = 15,
   parameter int PIX_BIT    = 8
);
   logic                  coef_valid;
   logic [COFCNT_BIT-1:0] coef_in;
   logic                  coef_ready;
   logic                  pix_valid;
   logic [PIX_BIT-1:0]    pix_in;
   logic                  pix_ready;
   logic                  data_out_valid;
   logic [DATA_BIT-1:0]   data_out;
   logic [DATA_IDBIT-1:0] data_id;
   modport master (
      input  coef_valid, coef_in, pix_valid, pix_in,
      output coef_ready, pix_ready, data_out_valid, data_out, data_id
   );
   modport slave (
      output coef_valid, coef_in, pix_valid, pix_in,
      input  coef_ready, pix_ready, data_out_valid, data_out, data_id
   );
endinterface

// File: rtl/im_stream_sender.sv
// im_stream_sender: sends MASK_WIDTH**2 coefficients then one raster frame of pixels to the filter,
// inserting H_BLANK idle cycles between rows; the filter cannot stall, so timing is owned here.
module im_stream_sender #(
   parameter int DATA_BIT   = 15,
   parameter int DATA_IDBIT = 1,
   parameter int ROW_WIDTH  = 640,
   parameter int COL_WIDTH  = 480,
   parameter int MASK_WIDTH = 7,
   parameter int CNT_BIT    = 10,
   parameter int COFCNT_BIT = 15,
   parameter int PIX_BIT    = 8,
   parameter int H_BLANK    = 4,
   parameter int ID_COEF    = 0,
   parameter int ID_PIX     = 1
) (
   input  logic                 clk,
   input  logic                 reset_in,
   input  logic                 start,
   im_stream_sender_if.master   s,
   output logic                 busy,
   output logic                 done
);
   localparam int NCOEF = MASK_WIDTH * MASK_WIDTH;
   typedef enum logic [2:0] {IDLE, COEF, PIX, BLANK, DONE} state_t;
   state_t state, state_nx;
   logic [CNT_BIT-1:0] coef_cnt, col, row, blank_cnt;
   logic coef_acc, pix_acc, coef_last, row_end, frame_end, blank_end;
   // Ready depends on state only, so an accept is simply ready-state & valid.
   assign coef_acc   = (state == COEF) && s.coef_valid;
   assign pix_acc    = (state == PIX) && s.pix_valid;
   assign coef_last  = coef_acc && coef_cnt == CNT_BIT'(NCOEF - 1);
   assign row_end    = pix_acc && col == CNT_BIT'(ROW_WIDTH - 1);
   assign frame_end  = row_end && row == CNT_BIT'(COL_WIDTH - 1);
   assign blank_end  = blank_cnt == CNT_BIT'(H_BLANK - 1);
   assign s.coef_ready = state == COEF;
   assign s.pix_ready  = state == PIX;
   assign busy         = state != IDLE;
   assign done         = state == DONE;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? COEF : IDLE;
         COEF:    state_nx = coef_last ? PIX : COEF;
         PIX:     state_nx = frame_end ? DONE : (row_end && H_BLANK > 0) ? BLANK : PIX;
         BLANK:   state_nx = blank_end ? PIX : BLANK;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state            <= IDLE;
         coef_cnt         <= '0;
         col              <= '0;
         row              <= '0;
         blank_cnt        <= '0;
         s.data_out_valid <= 1'b0;
         s.data_out       <= '0;
         s.data_id        <= DATA_IDBIT'(ID_COEF);
      end else begin
         state            <= state_nx;
         s.data_out_valid <= coef_acc || pix_acc;
         blank_cnt        <= (state == BLANK) ? blank_cnt + 1'b1 : '0;
         if (state == IDLE && start) begin
            coef_cnt <= '0;
            col      <= '0;
            row      <= '0;
         end
         if (coef_acc) begin
            coef_cnt   <= coef_cnt + 1'b1;
            s.data_out <= DATA_BIT'(s.coef_in);
            s.data_id  <= DATA_IDBIT'(ID_COEF);
         end
         if (pix_acc) begin
            col        <= row_end ? '0 : col + 1'b1;
            row        <= row_end ? row + 1'b1 : row;
            s.data_out <= DATA_BIT'(s.pix_in);
            s.data_id  <= DATA_IDBIT'(ID_PIX);
         end
      end
   end
endmodule

// File: tb/tb_im_stream_sender.sv
// tb_im_stream_sender: two senders (H_BLANK=2 and H_BLANK=0) driven by random sources; words and
// cycle timing are compared against expectations computed from the frame arithmetic.
module tb_im_stream_sender;
   localparam int RW = 4, CW = 3, MW = 3, NC = MW * MW, NP = RW * CW;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_in;
   logic [1:0] st = '0, cv = '0, pv = '0, rc, rp, ov, dn, bs;
   logic [14:0] cin [2];
   logic [7:0]  pin [2];
   logic [14:0] dout [2];
   logic        id [2];
   im_stream_sender_if ia();
   im_stream_sender_if ib();
   assign ia.coef_valid = cv[0];
   assign ia.coef_in    = cin[0];
   assign ia.pix_valid  = pv[0];
   assign ia.pix_in     = pin[0];
   assign rc[0]   = ia.coef_ready;
   assign rp[0]   = ia.pix_ready;
   assign ov[0]   = ia.data_out_valid;
   assign dout[0] = ia.data_out;
   assign id[0]   = ia.data_id;
   assign ib.coef_valid = cv[1];
   assign ib.coef_in    = cin[1];
   assign ib.pix_valid  = pv[1];
   assign ib.pix_in     = pin[1];
   assign rc[1]   = ib.coef_ready;
   assign rp[1]   = ib.pix_ready;
   assign ov[1]   = ib.data_out_valid;
   assign dout[1] = ib.data_out;
   assign id[1]   = ib.data_id;
   im_stream_sender #(.ROW_WIDTH(RW), .COL_WIDTH(CW), .MASK_WIDTH(MW), .H_BLANK(2)) dut_a (
      .clk(clk), .reset_in(reset_in), .start(st[0]), .s(ia), .busy(bs[0]), .done(dn[0]));
   im_stream_sender #(.ROW_WIDTH(RW), .COL_WIDTH(CW), .MASK_WIDTH(MW), .H_BLANK(0)) dut_b (
      .clk(clk), .reset_in(reset_in), .start(st[1]), .s(ib), .busy(bs[1]), .done(dn[1]));

   int tests = 0, fails = 0, nrec;
   logic [15:0] exp_q[$], got_q[$];
   logic [14:0] coefs [NC];
   logic [7:0]  pixs [NP];
   logic rv [128], rid [128], rdn [128], rbs [128], rrc [128], rrp [128];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output cycle of pixel k when both sources never stall (start in cycle 0).
   function automatic int pix_cyc(input int k, input int h);
      return NC + 2 + k + h * (k / RW);
   endfunction

   task automatic check_idle(input int d, input string tag);
      chk({tag, "_valid"}, ov[d], 0);
      chk({tag, "_busy"}, bs[d], 0);
      chk({tag, "_done"}, dn[d], 0);
      chk({tag, "_rdy"}, {rc[d], rp[d]}, 0);
      chk({tag, "_data"}, {id[d], dout[d]}, 0);
   endtask

   task automatic run(input int d, input bit stall, input bit inj, input int tail, input int abort_t);
      int h = d ? 0 : 2;
      int ci = 0, pi = 0, pc = 0, seen = -1, ndone = 0, last, s0, s1, s2;
      bit ev, epr;
      s0 = $urandom_range(0, 3);
      s1 = $urandom_range(4, 7);
      s2 = $urandom_range(8, 11);
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < NC; i++) begin
         coefs[i] = (stall && i == 0) ? 15'h7FFF : 15'($urandom);
         exp_q.push_back({1'b0, coefs[i]});
      end
      for (int i = 0; i < NP; i++) begin
         pixs[i] = (stall && i == 0) ? 8'hA5 : 8'($urandom);
         exp_q.push_back({1'b1, 7'b0, pixs[i]});
      end
      nrec = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (t < 128) begin
            rv[t] = ov[d]; rid[t] = id[d]; rdn[t] = dn[d];
            rbs[t] = bs[d]; rrc[t] = rc[d]; rrp[t] = rp[d];
            nrec = t + 1;
         end
         if (ov[d]) got_q.push_back({id[d], dout[d]});
         if (dn[d]) begin
            ndone++;
            if (seen < 0) seen = t;
            chk("done_with_last_pixel", {id[d], ov[d]}, 2'b11);
         end
         st[d] = (t == 0) || (inj && (t == 5 || t == 14 || t == 26));
         cv[d] = stall ? t[0] : 1'b1;
         cin[d] = (ci < NC) ? coefs[ci] : 15'($urandom);
         if (cv[d] && rc[d]) ci++;
         pv[d] = !(stall && (pc == s0 || pc == s1 || pc == s2));
         pin[d] = (pi < NP) ? pixs[pi] : 8'($urandom);
         if (rp[d]) begin
            pc++;
            if (pv[d]) pi++;
         end
         if (t == abort_t || (seen >= 0 && t == seen + tail)) break;
      end
      if (tail > 0 || abort_t >= 0) begin
         st[d] = 1'b0; cv[d] = 1'b0; pv[d] = 1'b0;
      end
      if (abort_t < 0) begin
         chk("done_count", ndone, 1);
         chk("word_count", got_q.size(), NC + NP);
         for (int i = 0; i < NC + NP && i < got_q.size(); i++)
            chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
         if (!stall) begin
            last = pix_cyc(NP - 1, h);
            for (int tt = 0; tt < nrec; tt++) begin
               ev = tt >= 2 && tt <= NC + 1;
               epr = 1'b0;
               for (int k = 0; k < NP; k++) begin
                  if (pix_cyc(k, h) == tt) ev = 1'b1;
                  if (pix_cyc(k, h) - 1 == tt) epr = 1'b1;
               end
               chk($sformatf("valid_t%0d", tt), rv[tt], ev);
               if (ev) chk($sformatf("id_t%0d", tt), rid[tt], tt > NC + 1);
               chk($sformatf("done_t%0d", tt), rdn[tt], tt == last);
               chk($sformatf("busy_t%0d", tt), rbs[tt], tt >= 1 && tt <= last);
               chk($sformatf("coef_ready_t%0d", tt), rrc[tt], tt >= 1 && tt <= NC);
               chk($sformatf("pix_ready_t%0d", tt), rrp[tt], epr);
            end
         end
      end
   endtask

   initial begin
      cin[0] = '0; cin[1] = '0; pin[0] = '0; pin[1] = '0;
      reset_in = 1'b1;
      #2 reset_in = 1'b0;
      repeat (3) @(negedge clk);
      check_idle(0, "reset_a");
      check_idle(1, "reset_b");
      reset_in = 1'b1;
      repeat (5) @(negedge clk);
      check_idle(0, "post_reset_a");
      check_idle(1, "post_reset_b");
      // full frame, always-valid sources, H_BLANK=2
      run(0, 1'b0, 1'b0, 3, -1);
      // stalled sources
      run(0, 1'b1, 1'b0, 3, -1);
      // start in COEF/BLANK/DONE ignored, then start in the first idle cycle
      run(0, 1'b0, 1'b1, 0, -1);
      run(0, 1'b0, 1'b0, 3, -1);
      // abort once row 1, column 2 is on data_out
      run(0, 1'b0, 1'b0, 3, pix_cyc(RW + 2, 2));
      chk("pre_abort_busy", bs[0], 1);
      chk("pre_abort_words", got_q.size(), NC + RW + 3);
      reset_in = 1'b0;
      #1;
      check_idle(0, "async_reset");
      repeat (2) @(negedge clk);
      reset_in = 1'b1;
      @(negedge clk);
      run(0, 1'b0, 1'b0, 3, -1);
      // H_BLANK=0 instance
      run(1, 1'b0, 1'b0, 3, -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
